// File: rtl/accel_spi_reader.sv
// Periodic SPI mode-0 reader for a 12-bit X/Y accelerometer (6-byte burst read per sample).
// Define ACCEL_INIT_EN to send a POWER_CTL measurement-mode write as the first frame after reset.
module accel_spi_reader #(
    parameter int CLK_DIV    = 50,
    parameter int SAMPLE_DIV = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MISO,
    output logic        SS,
    output logic        SCLK,
    output logic        MOSI,
    output logic [11:0] accel_x,
    output logic [11:0] accel_y,
    output logic        valid,
    output logic        busy
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int SMP_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(SAMPLE_DIV - 1);
    localparam logic [47:0] READ_FRAME  = {8'h0B, 8'h0E, 32'h0};
    localparam logic [47:0] WRITE_FRAME = {8'h0A, 8'h2D, 8'h02, 24'h0};
`ifdef ACCEL_INIT_EN
    localparam logic INIT_EN = 1'b1;
`else
    localparam logic INIT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [SMP_W-1:0] smp_q, smp_d;
    logic [5:0]       bit_q, bit_d;
    logic [47:0]      tx_q, tx_d;
    logic [31:0]      rx_q, rx_d;
    logic             pend_q, pend_d;
    logic             init_q, init_d;
    logic             wr_q, wr_d;
    logic             ss_q, ss_d;
    logic             sclk_q, sclk_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic [11:0]      ax_q, ax_d;
    logic [11:0]      ay_q, ay_d;
    logic             req;
    logic             div_done;
    logic [5:0]       last_bit;

    assign req      = (smp_q == SMP_LAST);
    assign div_done = (div_q == DIV_LAST);
    assign last_bit = wr_q ? 6'd23 : 6'd47;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        smp_d   = req ? '0 : smp_q + 1'b1;
        bit_d   = bit_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        pend_d  = pend_q;
        init_d  = init_q;
        wr_d    = wr_q;
        ss_d    = ss_q;
        sclk_d  = sclk_q;
        valid_d = 1'b0;
        busy_d  = busy_q;
        ax_d    = ax_q;
        ay_d    = ay_q;
        if (state_q != IDLE) begin
            div_d = div_done ? '0 : div_q + 1'b1;
            if (req) pend_d = 1'b1;
        end
        unique case (state_q)
            IDLE: begin
                if (init_q || req || pend_q) begin
                    state_d = SETUP;
                    ss_d    = 1'b0;
                    busy_d  = 1'b1;
                    div_d   = '0;
                    bit_d   = '0;
                    wr_d    = init_q;
                    init_d  = 1'b0;
                    tx_d    = init_q ? WRITE_FRAME : READ_FRAME;
                    // A sample request that coincides with the init write must still be served.
                    pend_d  = init_q && (req || pend_q);
                end
            end
            SETUP: begin
                if (div_done) state_d = SHIFT;
            end
            SHIFT: begin
                if (div_done) begin
                    sclk_d = ~sclk_q;
                    if (!sclk_q) begin
                        rx_d = {rx_q[30:0], MISO};
                    end else begin
                        tx_d  = {tx_q[46:0], 1'b0};
                        bit_d = bit_q + 1'b1;
                        if (bit_q == last_bit) state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (div_done) begin
                    state_d = GAP;
                    ss_d    = 1'b1;
                    if (!wr_q) begin
                        valid_d = 1'b1;
                        ax_d    = {rx_q[19:16], rx_q[31:24]};
                        ay_d    = {rx_q[3:0], rx_q[15:8]};
                    end
                end
            end
            GAP: begin
                if (div_done) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            div_q   <= '0;
            smp_q   <= '0;
            bit_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            pend_q  <= 1'b0;
            init_q  <= INIT_EN;
            wr_q    <= 1'b0;
            ss_q    <= 1'b1;
            sclk_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ax_q    <= '0;
            ay_q    <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            smp_q   <= smp_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            pend_q  <= pend_d;
            init_q  <= init_d;
            wr_q    <= wr_d;
            ss_q    <= ss_d;
            sclk_q  <= sclk_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            ax_q    <= ax_d;
            ay_q    <= ay_d;
        end
    end

    // MOSI is the head of the transmit shift register, so it only moves when the register shifts.
    assign SS      = ss_q;
    assign SCLK    = sclk_q;
    assign MOSI    = tx_q[47];
    assign accel_x = ax_q;
    assign accel_y = ay_q;
    assign valid   = valid_q;
    assign busy    = busy_q;
endmodule

// File: tb/tb_accel_spi_reader.sv
// Bench for accel_spi_reader: instance 0 samples every 200 clks, instance 1 every 50 clks
// (frame longer than the period); MISO data is random apart from one fixed sample.
`timescale 1ns/1ps
module tb_accel_spi_reader;
    localparam int CLK_DIV = 2;
    localparam logic [31:0] FIXED_DATA = 32'hFF07_0108;
`ifdef ACCEL_INIT_EN
    localparam int unsigned FIRST_RD = 1;
`else
    localparam int unsigned FIRST_RD = 0;
`endif

    typedef struct {
        int unsigned fall_t;
        int unsigned rise_t;
        int unsigned nedges;
        logic [47:0] mosi;
        logic [31:0] data;
        logic        v;
        logic [11:0] ax;
        logic [11:0] ay;
    } frame_t;

    // ---------------- clock / reset / DUTs ----------------
    logic clk = 1'b0;
    logic [1:0] rst_n;
    logic [1:0] miso_w, ss_w, sclk_w, mosi_w, valid_w, busy_w;
    logic [1:0][11:0] ax_w, ay_w;
    int unsigned cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    accel_spi_reader #(.CLK_DIV(CLK_DIV), .SAMPLE_DIV(200)) u_a (
        .clk(clk), .reset(rst_n[0]), .MISO(miso_w[0]), .SS(ss_w[0]), .SCLK(sclk_w[0]),
        .MOSI(mosi_w[0]), .accel_x(ax_w[0]), .accel_y(ay_w[0]), .valid(valid_w[0]), .busy(busy_w[0])
    );
    accel_spi_reader #(.CLK_DIV(CLK_DIV), .SAMPLE_DIV(50)) u_b (
        .clk(clk), .reset(rst_n[1]), .MISO(miso_w[1]), .SS(ss_w[1]), .SCLK(sclk_w[1]),
        .MOSI(mosi_w[1]), .accel_x(ax_w[1]), .accel_y(ay_w[1]), .valid(valid_w[1]), .busy(busy_w[1])
    );

    // ---------------- slave model and frame monitor ----------------
    int checks = 0;
    int errors = 0;
    int viol = 0;
    int mosi_chg = 0;
    int stray_valid = 0;
    frame_t fq_a[$];
    frame_t fq_b[$];
    logic [23:0] exp_q[$];

    logic [1:0] p_ss = 2'b11;
    logic [1:0] p_sclk = 2'b00;
    logic [1:0] p_mosi = 2'b00;
    logic [1:0] in_fr = 2'b00;
    int unsigned f_t[2];
    int unsigned n_r[2];
    int unsigned n_f[2];
    int unsigned started[2];
    logic [47:0] m_sr[2];
    logic [47:0] s_str[2];
    logic [31:0] d_cur[2];
    frame_t mon_fr;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (ss_w[i] && sclk_w[i]) viol++;
            if (mosi_w[i] !== p_mosi[i]) begin
                mosi_chg++;
                if (sclk_w[i] !== 1'b0) viol++;
            end
            if (valid_w[i] && !(!p_ss[i] && ss_w[i])) stray_valid++;
            if (p_ss[i] && !ss_w[i]) begin
                d_cur[i] = (i == 0 && started[0] == FIRST_RD) ? FIXED_DATA : $urandom;
                s_str[i] = {16'($urandom), d_cur[i]};
                f_t[i] = cyc;
                n_r[i] = 0;
                n_f[i] = 0;
                m_sr[i] = '0;
                in_fr[i] = 1'b1;
                started[i]++;
            end
            if (in_fr[i] && !ss_w[i]) begin
                if (!p_sclk[i] && sclk_w[i]) begin
                    n_r[i]++;
                    m_sr[i] = {m_sr[i][46:0], mosi_w[i]};
                end
                if (p_sclk[i] && !sclk_w[i]) n_f[i]++;
            end
            if (in_fr[i] && !p_ss[i] && ss_w[i]) begin
                mon_fr.fall_t = f_t[i];
                mon_fr.rise_t = cyc;
                mon_fr.nedges = n_r[i];
                mon_fr.mosi   = m_sr[i];
                mon_fr.data   = d_cur[i];
                mon_fr.v      = valid_w[i];
                mon_fr.ax     = ax_w[i];
                mon_fr.ay     = ay_w[i];
                if (i == 0) fq_a.push_back(mon_fr);
                else fq_b.push_back(mon_fr);
                in_fr[i] = 1'b0;
            end
            miso_w[i] = (!ss_w[i] && n_f[i] < 48) ? s_str[i][6'(47 - n_f[i])] : 1'b0;
            p_ss[i]   = ss_w[i];
            p_sclk[i] = sclk_w[i];
            p_mosi[i] = mosi_w[i];
        end
    end

    // ---------------- reference model and checking helpers ----------------
    function automatic logic [23:0] accel_model(input logic [31:0] data);
        logic [7:0] xl, xh, yl, yh;
        {xl, xh, yl, yh} = data;
        return {xh[3:0], xl, yh[3:0], yl};
    endfunction

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_frames(input int inst, input int n, input int budget);
        int t = 0;
        while (((inst == 0) ? fq_a.size() : fq_b.size()) < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk($sformatf("wait_frames_%0d", inst),
            48'(((inst == 0) ? fq_a.size() : fq_b.size()) >= n), 48'd1);
        if (((inst == 0) ? fq_a.size() : fq_b.size()) < n) begin
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    endtask

    task automatic check_frame(input string tag, input frame_t fr, input bit is_wr);
        int unsigned bits = is_wr ? 24 : 48;
        chk({tag, "_edges"}, 48'(fr.nedges), 48'(bits));
        chk({tag, "_ss_low"}, 48'(fr.rise_t - fr.fall_t), 48'(CLK_DIV * (2 * bits + 2)));
        chk({tag, "_mosi"}, fr.mosi, is_wr ? 48'h0A2D02 : 48'h0B0E_0000_0000);
        chk({tag, "_valid"}, 48'(fr.v), 48'(!is_wr));
        if (!is_wr) begin
            exp_q.push_back(accel_model(fr.data));
            chk({tag, "_accel"}, 48'({fr.ax, fr.ay}), 48'(exp_q.pop_front()));
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        frame_t fr;
        int unsigned rel_a, rel_b, prev_rise;
        int n, t;
        logic prev_sclk;
        logic [23:0] exp_xy;

        rst_n = 2'b00;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_ss_%0d", i), 48'(ss_w[i]), 48'd1);
            chk($sformatf("rst_sclk_%0d", i), 48'(sclk_w[i]), 48'd0);
            chk($sformatf("rst_mosi_%0d", i), 48'(mosi_w[i]), 48'd0);
            chk($sformatf("rst_valid_%0d", i), 48'(valid_w[i]), 48'd0);
            chk($sformatf("rst_busy_%0d", i), 48'(busy_w[i]), 48'd0);
            chk($sformatf("rst_accel_%0d", i), 48'({ax_w[i], ay_w[i]}), 48'd0);
        end
        rel_a = cyc;
        rel_b = cyc;
        rst_n = 2'b11;

        // Instance 0: one read every 200 clks, first carrying the fixed sample.
        wait_frames(0, int'(FIRST_RD) + 3, 1200);
`ifdef ACCEL_INIT_EN
        fr = fq_a.pop_front();
        chk("a_wr_fall", 48'(fr.fall_t - rel_a), 48'd1);
        check_frame("a_wr", fr, 1'b1);
`endif
        fr = fq_a.pop_front();
        chk("a_fall_0", 48'(fr.fall_t - rel_a), 48'd200);
        check_frame("a_rd_0", fr, 1'b0);
        chk("a_fixed_x", 48'(fr.ax), 48'h7FF);
        chk("a_fixed_y", 48'(fr.ay), 48'h801);
        for (int k = 1; k < 3; k++) begin
            fr = fq_a.pop_front();
            chk($sformatf("a_fall_%0d", k), 48'(fr.fall_t - rel_a), 48'(200 * (k + 1)));
            check_frame($sformatf("a_rd_%0d", k), fr, 1'b0);
        end
        @(negedge clk);
        exp_xy = accel_model(fr.data);
        chk("a_hold_x", 48'(ax_w[0]), 48'(exp_xy[23:12]));
        chk("a_hold_y", 48'(ay_w[0]), 48'(exp_xy[11:0]));
        chk("a_valid_one_cycle", 48'(valid_w[0]), 48'd0);

        // Abort the next frame of instance 0 at its 20th SCLK rising edge.
        n = 0;
        t = 0;
        prev_sclk = sclk_w[0];
        while (n < 20 && t < 400) begin
            @(negedge clk);
            if (!prev_sclk && sclk_w[0]) n++;
            prev_sclk = sclk_w[0];
            t++;
        end
        chk("a_abort_reach_20", 48'(n), 48'd20);
        rst_n[0] = 1'b0;
        @(negedge clk);
        chk("a_abort_ss", 48'(ss_w[0]), 48'd1);
        chk("a_abort_sclk", 48'(sclk_w[0]), 48'd0);
        chk("a_abort_valid", 48'(valid_w[0]), 48'd0);
        chk("a_abort_busy", 48'(busy_w[0]), 48'd0);
        chk("a_abort_accel", 48'({ax_w[0], ay_w[0]}), 48'd0);
        repeat (3) @(negedge clk);
        wait_frames(0, 1, 10);
        fr = fq_a.pop_front();
        chk("a_abort_edges", 48'(fr.nedges), 48'd20);
        chk("a_abort_frame_valid", 48'(fr.v), 48'd0);
        rel_a = cyc;
        rst_n[0] = 1'b1;
        wait_frames(0, 1, 400);
        fr = fq_a.pop_front();
`ifdef ACCEL_INIT_EN
        chk("a_rerel_fall", 48'(fr.fall_t - rel_a), 48'd1);
        check_frame("a_rerel", fr, 1'b1);
`else
        chk("a_rerel_fall", 48'(fr.fall_t - rel_a), 48'd200);
        check_frame("a_rerel", fr, 1'b0);
`endif

        // Instance 1: requests outpace frames, so frames run back to back with one GAP.
        wait_frames(1, 5, 800);
        fr = fq_b.pop_front();
`ifdef ACCEL_INIT_EN
        chk("b_fall_0", 48'(fr.fall_t - rel_b), 48'd1);
        check_frame("b_0", fr, 1'b1);
`else
        chk("b_fall_0", 48'(fr.fall_t - rel_b), 48'd50);
        check_frame("b_0", fr, 1'b0);
`endif
        prev_rise = fr.rise_t;
        for (int k = 1; k < 5; k++) begin
            fr = fq_b.pop_front();
            chk($sformatf("b_gap_%0d", k), 48'(fr.fall_t - prev_rise), 48'(CLK_DIV + 1));
            check_frame($sformatf("b_%0d", k), fr, 1'b0);
            prev_rise = fr.rise_t;
        end

        chk("spi_protocol", 48'(viol), 48'd0);
        chk("stray_valid", 48'(stray_valid), 48'd0);
        chk("mosi_activity", 48'(mosi_chg > 0), 48'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/accel_spi_reader.md
ACCEL_SPI_READER -- requirements
Module: accel_spi_reader

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50, meaning clk cycles per SCLK half-period (1 MHz SCLK at 100 MHz clk).
REQ-002 SHALL have parameter SAMPLE_DIV, default 1000000, meaning clk cycles between sample requests (10 ms).
REQ-003 SHALL have port clk  input  1  the single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port MISO  input  1  serial data from accelerometer.
REQ-006 SHALL have port SS  output  1  active-low slave select.
REQ-007 SHALL have port SCLK  output  1  SPI clock, mode 0 (idle low).
REQ-008 SHALL have port MOSI  output  1  serial data to accelerometer.
REQ-009 SHALL have port accel_x  output  12  signed X acceleration, two's complement.
REQ-010 SHALL have port accel_y  output  12  signed Y acceleration, two's complement.
REQ-011 SHALL have port valid  output  1  one-clk pulse when accel_x/accel_y update.
REQ-012 SHALL have port busy  output  1  high while SS is low or a frame is being set up or closed.

Function
REQ-013 SHALL run FSM states IDLE, SETUP, SHIFT, HOLD, GAP; IDLE->SETUP on pending request; SETUP->SHIFT after CLK_DIV cycles with SS low; SHIFT->HOLD after last bit's falling edge; HOLD->GAP raising SS after CLK_DIV cycles; GAP->IDLE after CLK_DIV cycles with SS high.
REQ-014 SHALL drive SS low on entry to SETUP and high on entry to GAP.
REQ-015 SHALL toggle SCLK every CLK_DIV clk cycles in SHIFT only; SCLK low in all other states.
REQ-016 SHALL shift MOSI MSB-first, changing only on SCLK falling edges (first bit valid from SETUP entry), and sample MISO on SCLK rising edges.
REQ-017 Read frame SHALL be 6 bytes / 48 SCLK periods: 0x0B, 0x0E, then 4 received bytes XL, XH, YL, YH; MOSI SHALL be 0 during received bytes.
REQ-018 accel_x SHALL be {XH[3:0], XL}, accel_y {YH[3:0], YL}; upper nibbles of XH/YH ignored.
REQ-019 accel_x, accel_y SHALL update and valid SHALL pulse high for exactly one clk cycle on the cycle SS rises at the end of a read frame; outputs hold otherwise.
REQ-020 A free-running sample counter SHALL count 0..SAMPLE_DIV-1 and raise a request on wrap to 0.
REQ-021 A request arriving while not IDLE SHALL set a one-deep pending flag; further requests while pending SHALL be dropped; pending frame starts on next IDLE cycle.
REQ-022 Request and IDLE in the same cycle SHALL start SETUP on the next cycle without setting pending.
REQ-023 busy SHALL be high from SETUP entry through last GAP cycle inclusive.

Reset
REQ-024 While reset is low at a clk edge: SS=1, SCLK=0, MOSI=0, accel_x=0, accel_y=0, valid=0, busy=0, FSM=IDLE, sample counter=0, pending=0.
REQ-025 Reset asserted mid-frame SHALL abort it; SS high on the next cycle; no valid pulse; outputs return to reset values.

Configuration
REQ-026 With ACCEL_INIT_EN defined, the first frame after reset SHALL be a 3-byte write 0x0A, 0x2D, 0x02 (POWER_CTL measurement mode) started immediately, with no valid pulse; reads follow per REQ-020.
REQ-027 Without ACCEL_INIT_EN, no write frame SHALL be generated; the first frame is the read at the first counter wrap.

Verification
REQ-028 Reset release, SAMPLE_DIV=200, CLK_DIV=2, no ACCEL_INIT_EN -> SS falls at cycle 200, 48 SCLK rising edges, MOSI bytes 0x0B,0x0E.
REQ-029 MISO model returns 0xFF,0x07,0x01,0x08 (XL,XH,YL,YH) -> accel_x=0x7FF, accel_y=0x801, valid high exactly 1 cycle at SS rise.
REQ-030 SAMPLE_DIV=50, CLK_DIV=2 (frame longer than period) -> frames back-to-back with one GAP, no overlapping SS low, one pending request serviced per frame.
REQ-031 reset low at 20th SCLK rising edge -> SS=1, SCLK=0 next cycle, valid never asserted, accel_x stays 0.
REQ-032 With ACCEL_INIT_EN, CLK_DIV=2 -> first frame 24 SCLK periods carrying 0x0A,0x2D,0x02, no valid; next frame is a read.
REQ-033 SPI checker over all tests -> MOSI changes only while SCLK low, SCLK low whenever SS high.
